// File: rtl/conv3x3_mac.sv
// conv3x3_mac: 3x3 signed MAC over streamed windows, bias add, Q15.16 rescale and 32-bit saturation.
// Build option CONV_RELU_EN clamps negative results to zero before the output register.
module conv3x3_mac #(
    parameter int IMG_W = 28,
    parameter int IMG_H = 28,
    parameter int FRAC  = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [287:0] win_data,
    input  logic         win_en,
    input  logic         w_we,
    input  logic [3:0]   w_addr,
    input  logic [31:0]  w_data,
    output logic [31:0]  pix_out,
    output logic         pix_valid,
    output logic         pix_last,
    output logic         frame_done
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_KEEP_MAX = CW'(IMG_W - 3);
    localparam logic [CW-1:0] COL_MAX      = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_MAX      = RW'(IMG_H - 3);
    localparam logic signed [67:0] SAT_MAX = {36'h0, 32'h7FFF_FFFF};
    localparam logic signed [67:0] SAT_MIN = {36'hF_FFFF_FFFF, 32'h8000_0000};

    logic signed [31:0] wgt [9];
    logic signed [31:0] bias;
    logic [CW-1:0]      col;
    logic [RW-1:0]      row;
    logic               keep;
    logic               last;
    logic signed [31:0] tap [9];

    logic signed [63:0] prod [9];
    logic               v1, l1;
    logic signed [65:0] rsum [3];
    logic               v2, l2;
    logic signed [67:0] total;
    logic signed [67:0] shifted;
    logic signed [31:0] res;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned k = 0; k < 9; k++) wgt[k] <= '0;
            bias <= '0;
        end else if (w_we) begin
            for (int unsigned k = 0; k < 9; k++)
                if (w_addr == 4'(k)) wgt[k] <= w_data;
            if (w_addr == 4'd9) bias <= w_data;
        end
    end

    always_comb begin
        keep = (col <= COL_KEEP_MAX);
        last = keep && (row == ROW_MAX) && (col == COL_KEEP_MAX);
        for (int unsigned k = 0; k < 9; k++) tap[k] = win_data[32*k +: 32];
    end

    // Anchor counters advance only on accepted windows; frame end wraps both to zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col <= '0;
            row <= '0;
        end else if (win_en) begin
            if (col == COL_MAX) begin
                col <= '0;
                row <= (row == ROW_MAX) ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned k = 0; k < 9; k++) prod[k] <= '0;
            for (int unsigned r = 0; r < 3; r++) rsum[r] <= '0;
            v1 <= 1'b0;
            l1 <= 1'b0;
            v2 <= 1'b0;
            l2 <= 1'b0;
        end else begin
            v1 <= win_en && keep;
            l1 <= win_en && last;
            for (int unsigned k = 0; k < 9; k++) prod[k] <= 64'(tap[k]) * 64'(wgt[k]);
            v2 <= v1;
            l2 <= l1;
            for (int unsigned r = 0; r < 3; r++)
                rsum[r] <= 66'(prod[3*r]) + 66'(prod[3*r+1]) + 66'(prod[3*r+2]);
        end
    end

    always_comb begin
        total   = 68'(rsum[0]) + 68'(rsum[1]) + 68'(rsum[2]) + (68'(bias) <<< FRAC);
        shifted = total >>> FRAC;
        if (shifted > SAT_MAX)      res = 32'h7FFF_FFFF;
        else if (shifted < SAT_MIN) res = 32'h8000_0000;
        else                        res = shifted[31:0];
`ifdef CONV_RELU_EN
        if (res[31]) res = '0;
`else
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix_out    <= '0;
            pix_valid  <= 1'b0;
            pix_last   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            pix_valid  <= v2;
            pix_last   <= v2 && l2;
            frame_done <= pix_last;
            if (v2) pix_out <= res;
        end
    end
endmodule

// File: tb/tb_conv3x3_mac.sv
// tb_conv3x3_mac: directed vector table plus frame, collision and mid-frame reset sequences.
module tb_conv3x3_mac;
    logic         clk = 1'b0;
    logic         rst;
    logic [287:0] win_data;
    logic         win_en;
    logic         w_we;
    logic [3:0]   w_addr;
    logic [31:0]  w_data;
    logic [31:0]  pix_out;
    logic         pix_valid;
    logic         pix_last;
    logic         frame_done;

    int total = 0;
    int bad   = 0;
    int ncyc  = 0;

    logic [31:0] got_q [$];
    int          last_idx [$];
    int          last_cyc [$];
    int          done_cyc [$];

    typedef struct {
        string       name;
        logic [31:0] tap;
        logic [31:0] wt;
        logic [31:0] bias;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs [8];

    always #5 clk = ~clk;

    conv3x3_mac #(.IMG_W(28), .IMG_H(28), .FRAC(16)) dut (
        .clk(clk), .rst(rst), .win_data(win_data), .win_en(win_en),
        .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
        .pix_out(pix_out), .pix_valid(pix_valid), .pix_last(pix_last), .frame_done(frame_done)
    );

    always @(negedge clk) begin
        ncyc++;
        if (pix_valid) begin
            if (pix_last) begin
                last_idx.push_back(got_q.size());
                last_cyc.push_back(ncyc);
            end
            got_q.push_back(pix_out);
        end
        if (frame_done) done_cyc.push_back(ncyc);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] relu(input logic [31:0] v);
`ifdef CONV_RELU_EN
        return v[31] ? 32'h0 : v;
`else
        return v;
`endif
    endfunction

    function automatic logic [287:0] centre(input logic [31:0] v);
        logic [287:0] w;
        w = '0;
        w[4*32 +: 32] = v;
        return w;
    endfunction

    task automatic step(input logic en, input logic [287:0] win, input logic we,
                        input logic [3:0] a, input logic [31:0] d);
        win_en   = en;
        win_data = win;
        w_we     = we;
        w_addr   = a;
        w_data   = d;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 4'd0, 32'h0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        idle(1);
    endtask

    task automatic clear_mon();
        got_q.delete();
        last_idx.delete();
        last_cyc.delete();
        done_cyc.delete();
    endtask

    task automatic stream(input int n, input bit bubbles);
        int sent = 0;
        int t = 0;
        while (sent < n) begin
            if (bubbles && (t % 7 == 6)) idle(1);
            else begin
                step(1'b1, centre(32'(sent)), 1'b0, 4'd0, 32'h0);
                sent++;
            end
            t++;
        end
    endtask

    task automatic verify_frame(input string tag, input int extra);
        int errs = 0;
        int grp_err = 0;
        int n = 0;
        logic [31:0] e;
        check({tag, "_count"}, got_q.size(), 676 + extra);
        for (int r = 0; r < 26; r++)
            for (int c = 0; c < 26; c++) begin
                e = 32'(r * 28 + c);
                if (n >= got_q.size() || got_q[n] !== e) errs++;
                n++;
            end
        for (int j = 0; j < extra; j++) begin
            e = 32'(728 + j);
            if (n >= got_q.size() || got_q[n] !== e) errs++;
            n++;
        end
        check({tag, "_values"}, errs, 0);
        for (int r = 0; r < 26; r++) begin
            int cnt = 0;
            foreach (got_q[i]) if (got_q[i] < 728 && (got_q[i] / 28) == r) cnt++;
            if (cnt != 26) grp_err++;
        end
        check({tag, "_edge_groups"}, grp_err, 0);
        check({tag, "_last_count"}, last_idx.size(), 1);
        check({tag, "_done_count"}, done_cyc.size(), 1);
        if (last_idx.size() > 0) check({tag, "_last_index"}, last_idx[0], 675);
        if (last_cyc.size() > 0 && done_cyc.size() > 0)
            check({tag, "_done_delay"}, done_cyc[0] - last_cyc[0], 1);
    endtask

    initial begin
        vecs[0] = '{"arith",     32'h0002_0000, 32'h0000_8000, 32'h0001_0000, 32'h000A_0000};
        vecs[1] = '{"sat_pos",   32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h0000_0000, 32'h7FFF_FFFF};
        vecs[2] = '{"sat_neg",   32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0000, relu(32'h8000_0000)};
        vecs[3] = '{"neg_exact", 32'hFFFF_0000, 32'h0001_0000, 32'h0000_0000, relu(32'hFFF7_0000)};
        vecs[4] = '{"floor_pos", 32'h0000_0001, 32'h0000_8000, 32'h0000_0000, 32'h0000_0004};
        vecs[5] = '{"floor_neg", 32'hFFFF_FFFF, 32'h0000_8000, 32'h0000_0000, relu(32'hFFFF_FFFB)};
        vecs[6] = '{"bias_only", 32'h0000_0000, 32'h7FFF_FFFF, 32'hFFFE_0000, relu(32'hFFFE_0000)};
        vecs[7] = '{"bias_sat",  32'h0001_0000, 32'h0001_0000, 32'h7FFF_FFFF, 32'h7FFF_FFFF};

        rst = 1'b0;
        win_en = 1'b0; win_data = '0; w_we = 1'b0; w_addr = '0; w_data = '0;
        #2;
        do_reset();
        check("rst_pix_out", pix_out, 32'h0);
        check("rst_pix_valid", 32'(pix_valid), 32'h0);
        check("rst_pix_last", 32'(pix_last), 32'h0);
        check("rst_frame_done", 32'(frame_done), 32'h0);

        for (int i = 0; i < 8; i++) begin
            for (int k = 0; k < 9; k++) step(1'b0, '0, 1'b1, 4'(k), vecs[i].wt);
            step(1'b0, '0, 1'b1, 4'd9, vecs[i].bias);
            step(1'b1, {9{vecs[i].tap}}, 1'b0, 4'd0, 32'h0);
            idle(1);
            check({vecs[i].name, "_early"}, 32'(pix_valid), 32'h0);
            idle(1);
            check({vecs[i].name, "_valid"}, 32'(pix_valid), 32'h1);
            check({vecs[i].name, "_value"}, pix_out, vecs[i].exp);
            idle(1);
            check({vecs[i].name, "_drop_valid"}, 32'(pix_valid), 32'h0);
            check({vecs[i].name, "_hold"}, pix_out, vecs[i].exp);
        end

        // Full frame with bubbles, then three windows of the next frame back to back.
        do_reset();
        step(1'b0, '0, 1'b1, 4'd4, 32'h0001_0000);
        idle(2);
        clear_mon();
        stream(731, 1'b1);
        idle(6);
        verify_frame("ident", 3);

        do_reset();
        step(1'b0, '0, 1'b1, 4'd4, 32'h0001_0000);
        idle(2);
        clear_mon();
        step(1'b1, centre(32'h0003_0000), 1'b1, 4'd4, 32'h0002_0000);
        step(1'b1, centre(32'h0003_0000), 1'b0, 4'd0, 32'h0);
        idle(5);
        check("coll_count", got_q.size(), 2);
        if (got_q.size() == 2) begin
            check("coll_old_weight", got_q[0], 32'h0003_0000);
            check("coll_new_weight", got_q[1], 32'h0006_0000);
        end

        do_reset();
        step(1'b0, '0, 1'b1, 4'd4, 32'h0001_0000);
        idle(2);
        clear_mon();
        stream(100, 1'b0);
        check("pre_rst_out", pix_out, 32'd97);
        rst = 1'b1;
        #1;
        check("midrst_pix_out", pix_out, 32'h0);
        check("midrst_pix_valid", 32'(pix_valid), 32'h0);
        check("midrst_pix_last", 32'(pix_last), 32'h0);
        check("pre_rst_count", got_q.size(), 91);
        idle(2);
        rst = 1'b0;
        idle(6);
        check("rst_no_ghost", got_q.size(), 91);
        step(1'b0, '0, 1'b1, 4'd4, 32'h0001_0000);
        idle(2);
        clear_mon();
        stream(728, 1'b0);
        idle(6);
        verify_frame("rst_frame", 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
